// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Control FSM for a multicycle RV32 subset (lw, sw, R-type, I-type ALU,
// beq/bne, jal, lui). This is a Moore machine: each output depends only on the
// current state. There are three exceptions:
//   - immSrc is decoded from op in every state.
//   - The FETCH enables follow memReady.
//   - The BRANCH pcWrite follows funct3/zero.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset; forces FETCH immediately
//   op          instr[6:0] from the instruction register
//   funct3      instr[14:12]
//   zero        ALU zero flag
//   memReady    memory handshake (see below)
//   pcWrite     PC register enable
//   adrSrc      memory address select: 0 = PC, 1 = ALUOut
//   memWrite    memory write strobe
//   irWrite     instruction register enable
//   resultSrc   00 ALUOut, 01 read data, 10 ALU result, 11 immExt
//   aluSrcA     00 PC, 01 oldPC, 10 register A
//   aluSrcB     00 register B, 01 immExt, 10 constant 4
//   aluOp       00 add, 01 subtract, 10 funct decode
//   regWrite    register file write enable
//   immSrc      immediate select: 000 I, 001 S, 010 B, 011 J, 100 U
//   illegal     unsupported-opcode flag
//   debug_state current FSM state encoding, for observation only
//
// Configuration macro: CTRL_ILLEGAL_TRAP_EN
//   When defined, an unsupported op seen in DECODE parks the FSM in ILLEGAL.
//   ILLEGAL raises illegal, and only reset leaves that state.
//   When undefined, an unsupported op returns to FETCH with no side effects.
//   In that build illegal is tied low.
//
// Handshake: the memory sees a request whenever the FSM sits in FETCH, MEMREAD
// or MEMWRITE. The address and strobes are held steady in those states. The
// access completes in the cycle where memReady=1, and the FSM then advances.
// memReady is ignored in every other state.
// -----------------------------------------------------------------------------
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       memReady,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic       regWrite,
    output logic [2:0] immSrc,
    output logic       illegal,
    output logic [3:0] debug_state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_LUI      = 4'd11;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic [3:0] S_ILLEGAL  = 4'd12;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic [3:0] state;
    logic [3:0] state_next;

    // Write enables before reset gating.
    logic pc_en;
    logic mem_en;
    logic ir_en;
    logic rw_en;

    assign debug_state = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (memReady) state_next = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD,
                    OP_STORE:  state_next = S_MEMADR;
                    OP_RTYPE:  state_next = S_EXECUTER;
                    OP_ITYPE:  state_next = S_EXECUTEI;
                    OP_BRANCH: state_next = S_BRANCH;
                    OP_JAL:    state_next = S_JAL;
                    OP_LUI:    state_next = S_LUI;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:   state_next = S_ILLEGAL;
`else
                    default:   state_next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR:   state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (memReady) state_next = S_MEMWB;
            end
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: begin
                if (memReady) state_next = S_FETCH;
            end
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            // jal writes the link address (oldPC + 4) through ALUWB.
            S_JAL:      state_next = S_ALUWB;
            S_LUI:      state_next = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_ILLEGAL:  state_next = S_ILLEGAL;
`endif
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_en     = 1'b0;
        adrSrc    = 1'b0;
        mem_en    = 1'b0;
        ir_en     = 1'b0;
        resultSrc = 2'b00;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        aluOp     = 2'b00;
        rw_en     = 1'b0;
        case (state)
            S_FETCH: begin
                // PC + 4 is routed straight to the PC while the instruction
                // is read. Both registers load on the completing cycle.
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                pc_en     = memReady;
                ir_en     = memReady;
            end
            S_DECODE: begin
                // Branch target (oldPC + imm) is precomputed into ALUOut.
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
            end
            S_MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            S_MEMREAD: begin
                adrSrc = 1'b1;
            end
            S_MEMWB: begin
                resultSrc = 2'b01;
                rw_en     = 1'b1;
            end
            S_MEMWRITE: begin
                // The strobe is held until memReady, so exactly one write is
                // accepted before the FSM leaves this state.
                adrSrc = 1'b1;
                mem_en = 1'b1;
            end
            S_EXECUTER: begin
                aluSrcA = 2'b10;
                aluOp   = 2'b10;
            end
            S_EXECUTEI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                aluOp   = 2'b10;
            end
            S_ALUWB: begin
                rw_en = 1'b1;
            end
            S_BRANCH: begin
                // beq: taken on zero. bne: taken on not zero.
                // Other funct3 values are not supported and never take.
                aluSrcA = 2'b10;
                aluOp   = 2'b01;
                pc_en   = ((funct3 == 3'b000) && zero) ||
                          ((funct3 == 3'b001) && !zero);
            end
            S_JAL: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b10;
                pc_en   = 1'b1;
            end
            S_LUI: begin
                resultSrc = 2'b11;
                rw_en     = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        case (op)
            OP_LOAD,
            OP_ITYPE:  immSrc = 3'b000;
            OP_STORE:  immSrc = 3'b001;
            OP_BRANCH: immSrc = 3'b010;
            OP_JAL:    immSrc = 3'b011;
            OP_LUI:    immSrc = 3'b100;
            default:   immSrc = 3'b000;
        endcase
    end

    // The state is already FETCH while reset is high. The FETCH enables follow
    // memReady, so the write enables are gated explicitly.
    assign pcWrite  = pc_en  & ~reset;
    assign memWrite = mem_en & ~reset;
    assign irWrite  = ir_en  & ~reset;
    assign regWrite = rw_en  & ~reset;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal = (state == S_ILLEGAL) & ~reset;
`else
    assign illegal = 1'b0;
`endif

endmodule
